// File: rtl/irq_priority_encoder_if.sv
// Request/index bundle between the IRQ encoder (master) and its consumer (slave).
// Index side is a valid/ack handshake; pending/overrun are status taps.
interface irq_priority_encoder_if #(
    parameter int N     = 8,
    parameter int IDX_W = 3
);
    logic [N-1:0]     req;
    logic [N-1:0]     mask;
    logic             ack;
    logic             clr_ovr;
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     pending;
    logic [N-1:0]     overrun;

    modport master (
        input  req, mask, ack, clr_ovr,
        output valid, idx, pending, overrun
    );

    modport slave (
        output req, mask, ack, clr_ovr,
        input  valid, idx, pending, overrun
    );
endinterface

// File: rtl/irq_priority_encoder.sv
// Captures request lines into a pending register and presents the highest enabled index.
// Latency: req edge to valid = 2 clk; ack to next valid = 2 clk (1-cycle gap); idx held until ack.
module irq_priority_encoder #(
    parameter int N         = 8,
    parameter int IDX_W     = 3,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    irq_priority_encoder_if.master  bus
);

    if (IDX_W != $clog2(N)) begin : g_bad_idx_w
        $error("IDX_W must equal clog2(N)");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     req_d_q;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     overrun_q, overrun_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [N-1:0]     set_vec;
    logic [N-1:0]     clr_vec;
    logic [N-1:0]     ovr_set;
    logic [N-1:0]     cand;

    // Ascending scan so the highest set bit is the last one written.
    function automatic logic [IDX_W-1:0] prio_enc(input logic [N-1:0] v);
        prio_enc = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) prio_enc = IDX_W'(i);
        end
    endfunction

    always_comb begin
        set_vec   = EDGE_MODE ? (bus.req & ~req_d_q) : bus.req;
        clr_vec   = '0;
        if (state_q == PRESENT && bus.ack) clr_vec = N'(1) << idx_q;
        // A fresh set outranks the ack clear on the same line.
        pending_d = (pending_q & ~clr_vec) | set_vec;
        ovr_set   = EDGE_MODE ? (set_vec & pending_q & ~clr_vec) : '0;
        overrun_d = (bus.clr_ovr ? '0 : overrun_q) | ovr_set;
        cand      = pending_q & bus.mask;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    idx_d   = prio_enc(cand);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                // Index stays frozen regardless of mask/req changes until consumed.
                if (bus.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_d_q   <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_d_q   <= bus.req;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            idx_q     <= idx_d;
        end
    end

    assign bus.valid   = (state_q == PRESENT);
    assign bus.idx     = idx_q;
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder: edge-mode and level-mode instances share clock and reset.
// Expected indices are queued when requests are driven and popped when valid is observed.
module tb_irq_priority_encoder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    irq_priority_encoder_if #(.N(8), .IDX_W(3)) e_if ();
    irq_priority_encoder_if #(.N(8), .IDX_W(3)) l_if ();

    irq_priority_encoder #(.N(8), .IDX_W(3), .EDGE_MODE(1'b1)) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (e_if)
    );

    irq_priority_encoder #(.N(8), .IDX_W(3), .EDGE_MODE(1'b0)) u_lvl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (l_if)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int exp_q[$];
    int exp_idx;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        e_if.req = '0; e_if.mask = 8'hFF; e_if.ack = 1'b0; e_if.clr_ovr = 1'b0;
        l_if.req = '0; l_if.mask = 8'hFF; l_if.ack = 1'b0; l_if.clr_ovr = 1'b0;
        tick(); tick();
        chk_cnt++; if (e_if.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", e_if.valid); else pass_cnt++;
        chk_cnt++; if (e_if.idx !== 3'd0) $display("FAIL reset_idx: got %0d want 0", e_if.idx); else pass_cnt++;
        chk_cnt++; if (e_if.pending !== 8'h00) $display("FAIL reset_pending: got %h want 00", e_if.pending); else pass_cnt++;
        chk_cnt++; if (e_if.overrun !== 8'h00) $display("FAIL reset_overrun: got %h want 00", e_if.overrun); else pass_cnt++;
        chk_cnt++; if (l_if.valid !== 1'b0) $display("FAIL reset_lvl_valid: got %b want 0", l_if.valid); else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_edge();
        e_if.req = 8'b0000_0100; exp_q.push_back(2);
        tick();
        e_if.req = '0;
        chk_cnt++; if (e_if.pending !== 8'h04) $display("FAIL single_pending: got %h want 04", e_if.pending); else pass_cnt++;
        chk_cnt++; if (e_if.valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", e_if.valid); else pass_cnt++;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1) $display("FAIL single_valid: got %b want 1", e_if.valid); else pass_cnt++;
        chk_cnt++; if (e_if.idx !== 3'(exp_idx)) $display("FAIL single_idx: got %0d want %0d", e_if.idx, exp_idx); else pass_cnt++;
        e_if.ack = 1'b1;
        tick();
        e_if.ack = 1'b0;
        chk_cnt++; if (e_if.valid !== 1'b0) $display("FAIL single_ack_valid: got %b want 0", e_if.valid); else pass_cnt++;
        chk_cnt++; if (e_if.pending !== 8'h00) $display("FAIL single_ack_pending: got %h want 00", e_if.pending); else pass_cnt++;
    endtask

    task automatic test_priority_hold();
        e_if.req = 8'b0001_0001; exp_q.push_back(4);
        tick();
        e_if.req = '0;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL prio_first: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        // Line 7 arrives while 4 is held; it is served before the remaining line 0.
        e_if.req = 8'b1000_0000; exp_q.push_back(7); exp_q.push_back(0);
        tick();
        e_if.req = '0;
        tick();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'd4)
            $display("FAIL prio_hold: got valid=%b idx=%0d want valid=1 idx=4", e_if.valid, e_if.idx); else pass_cnt++;
        chk_cnt++; if (e_if.pending !== 8'h91) $display("FAIL prio_pending: got %h want 91", e_if.pending); else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            e_if.ack = 1'b1;
            tick();
            e_if.ack = 1'b0;
            chk_cnt++; if (e_if.valid !== 1'b0) $display("FAIL prio_gap%0d: got valid=%b want 0", k, e_if.valid); else pass_cnt++;
            tick();
            exp_idx = exp_q.pop_front();
            chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
                $display("FAIL prio_next%0d: got valid=%b idx=%0d want valid=1 idx=%0d", k, e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        end
        e_if.ack = 1'b1;
        tick();
        e_if.ack = 1'b0;
        chk_cnt++; if (e_if.pending !== 8'h00 || e_if.valid !== 1'b0)
            $display("FAIL prio_drain: got pending=%h valid=%b want 00/0", e_if.pending, e_if.valid); else pass_cnt++;
    endtask

    task automatic test_mask();
        e_if.mask = 8'b0111_1111;
        e_if.req  = 8'b1000_0010; exp_q.push_back(1);
        tick();
        e_if.req = '0;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL mask_idx: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        chk_cnt++; if (e_if.pending !== 8'h82) $display("FAIL mask_retained: got %h want 82", e_if.pending); else pass_cnt++;
        e_if.mask = 8'hFF; exp_q.push_back(7);
        e_if.ack  = 1'b1;
        tick();
        e_if.ack = 1'b0;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL mask_unmask: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        e_if.mask = 8'h00;
        tick();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'd7)
            $display("FAIL mask_no_withdraw: got valid=%b idx=%0d want valid=1 idx=7", e_if.valid, e_if.idx); else pass_cnt++;
        e_if.ack = 1'b1;
        tick();
        e_if.ack = 1'b0;
        chk_cnt++; if (e_if.pending !== 8'h00) $display("FAIL mask_masked_ack: got %h want 00", e_if.pending); else pass_cnt++;
        e_if.req = 8'h08;
        tick();
        e_if.req = '0;
        e_if.ack = 1'b1;
        tick();
        e_if.ack = 1'b0;
        chk_cnt++; if (e_if.pending !== 8'h08 || e_if.valid !== 1'b0)
            $display("FAIL idle_ack_ignored: got pending=%h valid=%b want 08/0", e_if.pending, e_if.valid); else pass_cnt++;
        e_if.mask = 8'hFF; exp_q.push_back(3);
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL mask_late: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        e_if.ack = 1'b1;
        tick();
        e_if.ack = 1'b0;
        tick();
    endtask

    task automatic test_overrun();
        e_if.req = 8'h20; exp_q.push_back(5);
        tick();
        e_if.req = '0;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL ovr_present: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        e_if.req = 8'h20;
        tick();
        e_if.req = '0;
        chk_cnt++; if (e_if.overrun !== 8'h20) $display("FAIL ovr_set: got %h want 20", e_if.overrun); else pass_cnt++;
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'd5)
            $display("FAIL ovr_hold: got valid=%b idx=%0d want valid=1 idx=5", e_if.valid, e_if.idx); else pass_cnt++;
        e_if.clr_ovr = 1'b1;
        tick();
        e_if.clr_ovr = 1'b0;
        chk_cnt++; if (e_if.overrun !== 8'h00) $display("FAIL ovr_clear: got %h want 00", e_if.overrun); else pass_cnt++;
        // New edge lands on the same cycle the line is acked: it re-pends, no overrun.
        e_if.req = 8'h20; e_if.ack = 1'b1; exp_q.push_back(5);
        tick();
        e_if.req = '0; e_if.ack = 1'b0;
        chk_cnt++; if (e_if.pending !== 8'h20) $display("FAIL ovr_set_wins: got pending=%h want 20", e_if.pending); else pass_cnt++;
        chk_cnt++; if (e_if.overrun !== 8'h00) $display("FAIL ovr_same_cycle: got overrun=%h want 00", e_if.overrun); else pass_cnt++;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL ovr_represent: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        e_if.ack = 1'b1;
        tick();
        e_if.ack = 1'b0;
        chk_cnt++; if (e_if.pending !== 8'h00) $display("FAIL ovr_drain: got %h want 00", e_if.pending); else pass_cnt++;
    endtask

    task automatic test_level();
        l_if.req = 8'h08;
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(3);
            tick();
            exp_idx = exp_q.pop_front();
            chk_cnt++; if (l_if.valid !== 1'b1 || l_if.idx !== 3'(exp_idx))
                $display("FAIL lvl_present%0d: got valid=%b idx=%0d want valid=1 idx=%0d", k, l_if.valid, l_if.idx, exp_idx); else pass_cnt++;
            l_if.ack = 1'b1;
            tick();
            l_if.ack = 1'b0;
            chk_cnt++; if (l_if.valid !== 1'b0 || l_if.pending !== 8'h08)
                $display("FAIL lvl_gap%0d: got valid=%b pending=%h want 0/08", k, l_if.valid, l_if.pending); else pass_cnt++;
            chk_cnt++; if (l_if.overrun !== 8'h00) $display("FAIL lvl_overrun%0d: got %h want 00", k, l_if.overrun); else pass_cnt++;
        end
        l_if.req = '0;
    endtask

    task automatic test_async_reset();
        e_if.req = 8'h40; exp_q.push_back(6);
        tick();
        e_if.req = '0;
        tick();
        exp_idx = exp_q.pop_front();
        chk_cnt++; if (e_if.valid !== 1'b1 || e_if.idx !== 3'(exp_idx))
            $display("FAIL arst_present: got valid=%b idx=%0d want valid=1 idx=%0d", e_if.valid, e_if.idx, exp_idx); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (e_if.valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", e_if.valid); else pass_cnt++;
        chk_cnt++; if (e_if.pending !== 8'h00) $display("FAIL arst_pending: got %h want 00", e_if.pending); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk_cnt++; if (e_if.valid !== 1'b0 || e_if.pending !== 8'h00)
            $display("FAIL arst_after: got valid=%b pending=%h want 0/00", e_if.valid, e_if.pending); else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_edge();
        test_priority_hold();
        test_mask();
        test_overrun();
        test_level();
        test_async_reset();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/irq_priority_encoder.md
Name: irq_priority_encoder

Overview:
- Sequential front-end for the 8:3 encoder path. Captures eight interrupt request lines into a pending register and applies a per-line enable mask.
- Presents the index of the highest-priority pending, enabled line on a valid/ack handshake.
- Sits upstream of the index consumer (dispatch/vector logic). It replaces raw combinational one-hot encoding with held, acknowledged indices.

Parameters:
N, 8, number of request lines (MSB = highest priority)
IDX_W, 3, index width, must equal clog2(N)
EDGE_MODE, 1, 1 = pending set on rising edge of req; 0 = pending set while req high (level)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  request lines, synchronous to clk
mask  input  N  per-line enable, 1 = line may be presented
ack  input  1  consumer accepts presented index; meaningful only while valid=1
clr_ovr  input  1  clears overrun flags (synchronous, one cycle pulse)
valid  output  1  idx holds a presented request
idx  output  IDX_W  index of presented line (bit 7 -> 3'b111, bit 0 -> 3'b000)
pending  output  N  current pending register
overrun  output  N  sticky per-line flag: new request arrived while line already pending

Behaviour:
- Reset (async, rst_n=0): pending=0, overrun=0, req_d (previous req) =0, valid=0, idx=0, FSM=IDLE. Outputs change immediately on rst_n fall, not at next clk.
- Set detection:
  - EDGE_MODE=1: set[i] = req[i] & ~req_d[i].
  - EDGE_MODE=0: set[i] = req[i].
  - req_d resets to 0, so a line already high at reset release counts as an edge on the first clock.
- Pending update each clk: pending_next = (pending & ~clr) | set. clr is one-hot of idx only when valid & ack, else 0. Set wins over clear on the same bit in the same cycle.
- Overrun:
  - overrun[i] sets when set[i]=1 and pending[i]=1 and that bit is not being cleared in that cycle.
  - EDGE_MODE=0 never sets overrun; a held level is not an overrun.
  - clr_ovr=1 clears all bits. If a set condition occurs in the same cycle, set wins.
- Candidate: cand = pending & mask. Priority is highest index first; pending bits that are masked are retained, not presented.
- FSM, 2 states:
  - IDLE: valid=0. If cand != 0, latch idx = highest set bit of cand, go PRESENT. The index is registered, so valid rises 1 clk after the pending bit is visible. From req edge to valid = 2 clks.
  - PRESENT: valid=1, idx held stable regardless of later higher-priority arrivals, mask changes or req changes. On ack=1, clear pending[idx] and go IDLE (valid=0 next cycle). ack=0 stays in PRESENT indefinitely.
- Throughput: ack at edge t, valid low during t+1, next index valid at t+2 if a candidate exists. Back-to-back presentation has a mandatory 1-cycle gap.
- Masking an already-presented line does not withdraw it; it completes on ack.
- ack while valid=0 is ignored and causes no pending change.
- Reset mid-PRESENT: valid drops asynchronously, pending is lost, and no ack is required after release.
- Arithmetic: idx is an N-to-IDX_W priority encode. With cand=0, no latch occurs and idx keeps its last value.

Test Plan:
- Reset and single edge: after reset, pulse req=8'b0000_0100 for 1 clk -> pending[2]=1 at t+1, valid=1 with idx=3'b010 at t+2; ack 1 clk -> valid=0 next clk, pending=0.
- Priority and hold: req rises 8'b0001_0001, then 8'b1000_0000 arrives while idx=4 is presented -> idx stays 4 until ack. Next presentations: 7, then 0, each after a 1-cycle valid-low gap.
- Mask: mask=8'b0111_1111, req edge on bit 7 and bit 1 -> idx=1 presented, pending[7] stays 1. Set mask=8'hFF -> idx=7 presented after ack of 1.
- Overrun and simultaneous set/clear: with line 5 pending and unacked, a second edge on req[5] -> overrun[5]=1. An edge on req[5] in the same cycle as ack of idx=5 -> pending[5] remains 1, overrun[5] unchanged. clr_ovr -> overrun=0.
- Level mode (EDGE_MODE=0): hold req[3]=1 -> idx=3 re-presented after each ack (ack, gap, valid) and overrun stays 0.
- Async reset mid-operation: assert rst_n=0 between clk edges while valid=1, idx=6 -> valid=0, pending=0 immediately. After release with req=0, valid stays 0.
